// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard detection unit that sits beside the ID stage of the RV32 pipeline.
// In-flight loads are tracked in a small scoreboard. Each entry holds the
// load's destination register and a countdown of the cycles left until the
// load result can be used. The unit raises these signals:
//   - stall on load-use hazards (an ID source matches a pending load rd)
//   - stall on structural hazards (a load in ID while the scoreboard is full)
//   - a multi-cycle front-end flush after a taken branch
//
// Optional feature (compile-time macro HDU_STORE_BYPASS_EN):
//   When the macro is defined, a store is not stalled by an rs2 hazard if
//   every matching entry completes this cycle (its countdown equals 1). The
//   datapath forwards that store data MEM->MEM. Hazards on rs1, the address
//   source, still stall. When the macro is undefined, stores stall like any
//   other consumer.
//
// Parameters:
//   REG_AW       register address width (2**REG_AW architectural registers)
//   LOAD_LAT     cycles after issue during which a load result is unavailable
//                (1..7)
//   MAX_PEND     number of scoreboard entries
//   FLUSH_CYCLES cycles that flush stays high after a taken branch (1..7)
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           synchronous reset, active-high
//   i_id_valid      ID holds a valid instruction
//   i_id_opcode     opcode of the ID instruction
//   i_id_rs1        source register 1 of the ID instruction
//   i_id_rs2        source register 2 of the ID instruction
//   i_id_rd         destination register of the ID instruction
//   i_id_reg_write  the ID instruction writes rd
//   i_branch_taken  EX resolved a taken branch or jump this cycle
//   o_stall         hold PC and IF/ID, and inject a bubble into ID/EX
//   o_flush         kill the contents of IF/ID
//   o_pend_count    number of valid scoreboard entries
//
// Handshake: an ID instruction issues in a cycle where i_id_valid=1,
// o_stall=0 and o_flush=0. Only issued loads allocate an entry.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MAX_PEND     = 4,
    parameter int FLUSH_CYCLES = 2,
    localparam int CNT_W       = $clog2(MAX_PEND + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [6:0]        i_id_opcode,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_branch_taken,
    output logic              o_stall,
    output logic              o_flush,
    output logic [CNT_W-1:0]  o_pend_count
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Scoreboard state
    logic [MAX_PEND-1:0] r_valid;
    logic [REG_AW-1:0]   r_rd  [MAX_PEND];
    logic [2:0]          r_cnt [MAX_PEND];
    logic [2:0]          r_flush_cnt;

    // Decode of the ID instruction
    logic w_is_load;
    logic w_is_store;
    logic w_rs1_used;
    logic w_rs2_used;

    assign w_is_load  = (i_id_opcode == OP_LOAD);
    assign w_is_store = (i_id_opcode == OP_STORE);
    assign w_rs1_used = (i_id_opcode != OP_LUI) && (i_id_opcode != OP_AUIPC) &&
                        (i_id_opcode != OP_JAL);
    assign w_rs2_used = (i_id_opcode == OP_R) || w_is_store || (i_id_opcode == OP_BR);

    // Scoreboard lookup, occupancy and free-slot selection
    logic                w_match_rs1;
    logic                w_match_rs2;
    logic                w_full;
    logic                w_found;
    logic [MAX_PEND-1:0] w_alloc_oh;
    logic [CNT_W-1:0]    w_pend;
`ifdef HDU_STORE_BYPASS_EN
    logic                w_rs2_late;
`endif

    always_comb begin
        w_match_rs1 = 1'b0;
        w_match_rs2 = 1'b0;
        w_full      = 1'b1;
        w_found     = 1'b0;
        w_alloc_oh  = '0;
        w_pend      = '0;
`ifdef HDU_STORE_BYPASS_EN
        w_rs2_late  = 1'b0;
`endif
        for (int i = 0; i < MAX_PEND; i++) begin
            if (r_valid[i]) begin
                w_pend = w_pend + CNT_W'(1);
                if (r_rd[i] == i_id_rs1) begin
                    w_match_rs1 = 1'b1;
                end
                if (r_rd[i] == i_id_rs2) begin
                    w_match_rs2 = 1'b1;
`ifdef HDU_STORE_BYPASS_EN
                    // This matching load does not complete this cycle, so
                    // its data cannot be forwarded MEM->MEM.
                    if (r_cnt[i] != 3'd1) begin
                        w_rs2_late = 1'b1;
                    end
`endif
                end
            end else begin
                w_full = 1'b0;
                // Select the lowest free slot. Slots freed at this edge
                // are not visible here, so they are reused from the next
                // cycle.
                if (!w_found) begin
                    w_alloc_oh[i] = 1'b1;
                    w_found       = 1'b1;
                end
            end
        end
    end

    // Hazard evaluation
    logic w_rs1_hz;
    logic w_rs2_hz;
    logic w_data_hz;
    logic w_struct_hz;
    logic w_issue;
    logic w_alloc;

    assign w_rs1_hz = w_rs1_used && (i_id_rs1 != '0) && w_match_rs1;

`ifdef HDU_STORE_BYPASS_EN
    assign w_rs2_hz = w_rs2_used && (i_id_rs2 != '0) && w_match_rs2 &&
                      !(w_is_store && !w_rs2_late);
`else
    assign w_rs2_hz = w_rs2_used && (i_id_rs2 != '0) && w_match_rs2;
`endif

    assign w_data_hz   = i_id_valid && (w_rs1_hz || w_rs2_hz);
    // Full is taken at cycle start. A same-cycle free does not clear the
    // hazard, which keeps this path short.
    assign w_struct_hz = i_id_valid && w_is_load && w_full;

    // Flush has priority over stall because the ID instruction is being
    // killed anyway. Both outputs are forced low while reset is held.
    assign o_flush = !i_rst && (i_branch_taken || (r_flush_cnt != 3'd0));
    assign o_stall = !i_rst && (w_data_hz || w_struct_hz) && !o_flush;

    assign w_issue = i_id_valid && !o_stall && !o_flush;
    assign w_alloc = w_issue && w_is_load && i_id_reg_write && (i_id_rd != '0);

    assign o_pend_count = w_pend;

    // State update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= '0;
            r_flush_cnt <= 3'd0;
            for (int i = 0; i < MAX_PEND; i++) begin
                r_rd[i]  <= '0;
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < MAX_PEND; i++) begin
                if (w_alloc && w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_rd[i]    <= i_id_rd;
                    r_cnt[i]   <= 3'(LOAD_LAT);
                end else if (r_valid[i]) begin
                    // The final cycle of the countdown frees the entry.
                    if (r_cnt[i] == 3'd1) begin
                        r_valid[i] <= 1'b0;
                    end
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end

            if (i_branch_taken) begin
                r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
            end else if (r_flush_cnt != 3'd0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Bench for hazard_scoreboard configured with LOAD_LAT=3, MAX_PEND=2 and
// FLUSH_CYCLES=2. A timestamp model tracks each in-flight load by its issue
// cycle. A load is pending while cyc <= issue + LOAD_LAT. The model also
// records the cycle of the most recent taken branch. Each scenario task
// drives ID instructions, holds an instruction until the DUT lets it issue,
// and compares stall, flush and pend_count against the model every cycle.
// The bench follows HDU_STORE_BYPASS_EN in the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int REG_AW       = 5;
    localparam int LOAD_LAT     = 3;
    localparam int MAX_PEND     = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = $clog2(MAX_PEND + 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic [6:0]        op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rw;
    } instr_t;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              branch_taken;
    logic              stall;
    logic              flush;
    logic [CNT_W-1:0]  pend_count;

    hazard_scoreboard #(
        .REG_AW       (REG_AW),
        .LOAD_LAT     (LOAD_LAT),
        .MAX_PEND     (MAX_PEND),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_opcode    (id_opcode),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_reg_write),
        .i_branch_taken (branch_taken),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_pend_count   (pend_count)
    );

    // Reference model state
    int                cyc;
    int                q_cyc[$];
    logic [REG_AW-1:0] q_rd[$];
    int                last_br;
    logic              e_stall;
    logic              e_flush;
    logic              e_issue;
    logic [CNT_W-1:0]  e_pend;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic instr_t mk(input logic [6:0] op, input int rs1, input int rs2,
                                  input int rd, input logic rw);
        instr_t t;
        t.op  = op;
        t.rs1 = REG_AW'(rs1);
        t.rs2 = REG_AW'(rs2);
        t.rd  = REG_AW'(rd);
        t.rw  = rw;
        return t;
    endfunction

    // Drive one cycle of inputs and predict the expected outputs.
    task automatic apply(input logic v, input instr_t ins, input logic br, input logic r);
        logic rs1u, rs2u, h1, h2, h2_late, sh;
        rst          = r;
        id_valid     = v;
        id_opcode    = ins.op;
        id_rs1       = ins.rs1;
        id_rs2       = ins.rs2;
        id_rd        = ins.rd;
        id_reg_write = ins.rw;
        branch_taken = br;
        #1;
        while (q_cyc.size() > 0 && cyc > q_cyc[0] + LOAD_LAT) begin
            void'(q_cyc.pop_front());
            void'(q_rd.pop_front());
        end
        rs1u = !(ins.op == OP_LUI || ins.op == OP_AUIPC || ins.op == OP_JAL);
        rs2u = (ins.op == OP_R || ins.op == OP_STORE || ins.op == OP_BR);
        h1 = 1'b0;
        h2 = 1'b0;
        h2_late = 1'b0;
        for (int k = 0; k < q_rd.size(); k++) begin
            if (rs1u && ins.rs1 != 0 && q_rd[k] == ins.rs1) h1 = 1'b1;
            if (rs2u && ins.rs2 != 0 && q_rd[k] == ins.rs2) begin
                h2 = 1'b1;
                if (q_cyc[k] + LOAD_LAT != cyc) h2_late = 1'b1;
            end
        end
`ifdef HDU_STORE_BYPASS_EN
        if (ins.op == OP_STORE && !h2_late) h2 = 1'b0;
`endif
        sh      = (ins.op == OP_LOAD) && (q_cyc.size() == MAX_PEND);
        e_flush = !r && (br || (cyc - last_br < FLUSH_CYCLES));
        e_stall = !r && v && (h1 || h2 || sh) && !e_flush;
        e_issue = v && !e_stall && !e_flush;
        e_pend  = CNT_W'(q_cyc.size());
    endtask

    // Clock edge: commit the model update for the cycle just checked.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            q_cyc.delete();
            q_rd.delete();
            last_br = -1000;
        end else begin
            if (branch_taken) last_br = cyc;
            if (e_issue && id_opcode == OP_LOAD && id_reg_write && id_rd != 0) begin
                q_cyc.push_back(cyc);
                q_rd.push_back(id_rd);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(1'b0, mk(OP_I, 0, 0, 0, 1'b0), 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset();
        // Reset held with a load in ID and a branch: outputs are forced low.
        apply(1'b1, mk(OP_LOAD, 1, 0, 3, 1'b1), 1'b1, 1'b1);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush); end
        n_checks++; if (pend_count !== '0) begin n_fail++; $display("FAIL reset_pend got=%0d exp=0", pend_count); end
        advance();
        apply(1'b0, mk(OP_I, 0, 0, 0, 1'b0), 1'b0, 1'b0);
        n_checks++; if (flush !== e_flush) begin n_fail++; $display("FAIL post_reset_flush got=%b exp=%b", flush, e_flush); end
        n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL post_reset_pend got=%0d exp=%0d", pend_count, e_pend); end
        advance();
    endtask

    task automatic test_load_use();
        instr_t prog[6];
        int     st[6];
        logic   done;
        prog = '{mk(OP_LOAD, 1, 0, 4, 1'b1), mk(OP_R, 4, 0, 5, 1'b1),
                 mk(OP_LOAD, 1, 0, 4, 1'b1), mk(OP_I, 6, 0, 7, 1'b1),
                 mk(OP_LUI, 4, 4, 9, 1'b1), mk(OP_R, 6, 4, 8, 1'b1)};
        for (int n = 0; n < 6; n++) begin
            st[n] = 0;
            done  = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                apply(1'b1, prog[n], 1'b0, 1'b0);
                n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL load_use_stall i=%0d got=%b exp=%b", n, stall, e_stall); end
                n_checks++; if (flush !== e_flush) begin n_fail++; $display("FAIL load_use_flush i=%0d got=%b exp=%b", n, flush, e_flush); end
                n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL load_use_pend i=%0d got=%0d exp=%0d", n, pend_count, e_pend); end
                if (stall === 1'b1) st[n]++;
                done = (stall === 1'b0) && (flush === 1'b0);
                advance();
            end
            n_checks++; if (!done) begin n_fail++; $display("FAIL load_use_timeout i=%0d got=stuck exp=issue", n); end
        end
        // A dependent add stalls exactly LOAD_LAT cycles. Instructions that
        // use only x6, or that do not read rs1 (LUI), never stall.
        n_checks++; if (st[1] != LOAD_LAT) begin n_fail++; $display("FAIL load_use_penalty got=%0d exp=%0d", st[1], LOAD_LAT); end
        n_checks++; if (st[3] != 0) begin n_fail++; $display("FAIL independent_stall got=%0d exp=0", st[3]); end
        n_checks++; if (st[4] != 0) begin n_fail++; $display("FAIL lui_stall got=%0d exp=0", st[4]); end
    endtask

    task automatic test_struct();
        instr_t prog[5];
        int     st[5];
        logic   done;
        idle(LOAD_LAT + 1);
        prog = '{mk(OP_LOAD, 0, 0, 1, 1'b1), mk(OP_LOAD, 0, 0, 2, 1'b1),
                 mk(OP_LOAD, 0, 0, 3, 1'b1), mk(OP_LOAD, 0, 0, 0, 1'b1),
                 mk(OP_R, 0, 0, 10, 1'b1)};
        for (int n = 0; n < 5; n++) begin
            st[n] = 0;
            done  = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                apply(1'b1, prog[n], 1'b0, 1'b0);
                n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL struct_stall i=%0d got=%b exp=%b", n, stall, e_stall); end
                n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL struct_pend i=%0d got=%0d exp=%0d", n, pend_count, e_pend); end
                n_checks++; if (pend_count > MAX_PEND) begin n_fail++; $display("FAIL struct_overflow got=%0d exp<=%0d", pend_count, MAX_PEND); end
                if (stall === 1'b1) st[n]++;
                done = (stall === 1'b0) && (flush === 1'b0);
                advance();
            end
            n_checks++; if (!done) begin n_fail++; $display("FAIL struct_timeout i=%0d got=stuck exp=issue", n); end
        end
        // The third load waits until the first entry frees.
        n_checks++; if (st[2] != LOAD_LAT - (MAX_PEND - 1)) begin n_fail++; $display("FAIL struct_penalty got=%0d exp=%0d", st[2], LOAD_LAT - (MAX_PEND - 1)); end
    endtask

    task automatic test_flush();
        logic br_pat[4];
        logic fl_pat[4];
        br_pat = '{1'b1, 1'b1, 1'b0, 1'b0};
        fl_pat = '{1'b1, 1'b1, 1'b1, 1'b0};
        idle(LOAD_LAT + 1);
        apply(1'b1, mk(OP_LOAD, 0, 0, 9, 1'b1), 1'b0, 1'b0);
        advance();
        // A dependent add sits in ID while two back-to-back branches resolve.
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, mk(OP_R, 9, 0, 11, 1'b1), br_pat[k], 1'b0);
            n_checks++; if (flush !== fl_pat[k]) begin n_fail++; $display("FAIL flush_window k=%0d got=%b exp=%b", k, flush, fl_pat[k]); end
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL flush_stall k=%0d got=%b exp=%b", k, stall, e_stall); end
            n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL flush_pend k=%0d got=%0d exp=%0d", k, pend_count, e_pend); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        idle(LOAD_LAT + 1);
        apply(1'b1, mk(OP_LOAD, 0, 0, 1, 1'b1), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(OP_LOAD, 0, 0, 2, 1'b1), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(OP_R, 1, 2, 12, 1'b1), 1'b1, 1'b0);
        n_checks++; if (flush !== e_flush) begin n_fail++; $display("FAIL rmid_flush got=%b exp=%b", flush, e_flush); end
        n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL rmid_pend got=%0d exp=%0d", pend_count, e_pend); end
        advance();
        apply(1'b1, mk(OP_R, 1, 2, 12, 1'b1), 1'b0, 1'b1);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_stall got=%b exp=0", stall); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_flush got=%b exp=0", flush); end
        advance();
        apply(1'b1, mk(OP_R, 1, 2, 12, 1'b1), 1'b0, 1'b0);
        n_checks++; if (pend_count !== '0) begin n_fail++; $display("FAIL rmid_after_pend got=%0d exp=0", pend_count); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_after_stall got=%b exp=0", stall); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rmid_after_flush got=%b exp=0", flush); end
        advance();
    endtask

    task automatic test_store();
        instr_t prog[4];
        int     st[4];
        int     exp_sw;
        logic   done;
        idle(LOAD_LAT + 1);
        prog = '{mk(OP_LOAD, 0, 0, 7, 1'b1), mk(OP_STORE, 2, 7, 0, 1'b0),
                 mk(OP_LOAD, 0, 0, 8, 1'b1), mk(OP_STORE, 8, 0, 0, 1'b0)};
        for (int n = 0; n < 4; n++) begin
            st[n] = 0;
            done  = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                apply(1'b1, prog[n], 1'b0, 1'b0);
                n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL store_stall i=%0d got=%b exp=%b", n, stall, e_stall); end
                n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL store_pend i=%0d got=%0d exp=%0d", n, pend_count, e_pend); end
                if (stall === 1'b1) st[n]++;
                done = (stall === 1'b0) && (flush === 1'b0);
                advance();
            end
            n_checks++; if (!done) begin n_fail++; $display("FAIL store_timeout i=%0d got=stuck exp=issue", n); end
        end
`ifdef HDU_STORE_BYPASS_EN
        exp_sw = LOAD_LAT - 1;
`else
        exp_sw = LOAD_LAT;
`endif
        n_checks++; if (st[1] != exp_sw) begin n_fail++; $display("FAIL store_data_penalty got=%0d exp=%0d", st[1], exp_sw); end
        n_checks++; if (st[3] != LOAD_LAT) begin n_fail++; $display("FAIL store_addr_penalty got=%0d exp=%0d", st[3], LOAD_LAT); end
    endtask

    task automatic test_random();
        logic [6:0] ops[9];
        instr_t     ins;
        logic       v, br, r;
        ops = '{OP_LOAD, OP_LOAD, OP_STORE, OP_R, OP_BR, OP_I, OP_LUI, OP_AUIPC, OP_JAL};
        for (int k = 0; k < 600; k++) begin
            ins = mk((k % 7 == 0) ? OP_JALR : ops[$urandom_range(0, 8)],
                     $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
            v  = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 59) == 0);
            apply(v, ins, br, r);
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rand_stall k=%0d got=%b exp=%b", k, stall, e_stall); end
            n_checks++; if (flush !== e_flush) begin n_fail++; $display("FAIL rand_flush k=%0d got=%b exp=%b", k, flush, e_flush); end
            n_checks++; if (pend_count !== e_pend) begin n_fail++; $display("FAIL rand_pend k=%0d got=%0d exp=%0d", k, pend_count, e_pend); end
            advance();
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_opcode    = OP_I;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        branch_taken = 1'b0;
        cyc          = 0;
        last_br      = -1000;
        repeat (2) @(posedge clk);
        @(negedge clk);

        test_reset();
        test_load_use();
        test_struct();
        test_flush();
        test_reset_mid();
        test_store();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard detection unit of the RV32 core. It sits beside the ID stage and tracks in-flight loads in a small scoreboard with per-entry latency countdowns. It stalls ID on load-use and structural (scoreboard-full) hazards, and drives a multi-cycle front-end flush after a taken branch. Load latency, scoreboard depth and branch penalty are all configurable.

## Interface
- REG_AW, 5, register address width (2**REG_AW architectural registers)
- LOAD_LAT, 1, cycles after issue during which a load result is unavailable (1..7)
- MAX_PEND, 4, number of scoreboard entries (in-flight loads tracked)
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (1..7)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  7  ID instruction opcode
- id_rs1  in  REG_AW  ID source 1
- id_rs2  in  REG_AW  ID source 2
- id_rd  in  REG_AW  ID destination
- id_reg_write  in  1  ID instruction writes rd
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- flush  out  1  kill IF/ID contents
- pend_count  out  $clog2(MAX_PEND+1)  valid scoreboard entries

## Operation
- Entry = {valid, rd, cnt[2:0]}; MAX_PEND entries.
- issue = id_valid & ~stall & ~flush.
- Load = opcode 0000011. An issued load with id_reg_write=1 and id_rd≠0 allocates the lowest free entry: rd=id_rd, cnt=LOAD_LAT.
- Every cycle, each valid entry decrements cnt. An entry whose cnt is 1 at the edge is freed at that edge.
- Allocation and free may occur in the same cycle. A freed slot is reusable from the next cycle.
- Source use:
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only by 0110011 (R), 0100011 (store) and 1100011 (branch).
- data_hz = id_valid & ((rs1 used & rs1≠0 & rs1 matches any valid entry rd) | (rs2 used & rs2≠0 & rs2 matches any valid entry rd)).
- struct_hz = id_valid & ID is a load & all MAX_PEND entries valid at cycle start. Conservative: a same-cycle free does not clear it.
- stall = (data_hz | struct_hz) & ~flush. Flush has priority because the ID instruction is being killed.
- Duplicate rd across entries is legal. A match on any entry stalls.
- Branch handling:
  - flush = branch_taken | (flush_cnt≠0).
  - branch_taken loads flush_cnt=FLUSH_CYCLES-1.
  - Otherwise flush_cnt decrements to 0.
  - A new branch_taken while flush_cnt≠0 reloads it.
- Existing entries are older than the branch and are not cleared by flush.

## Timing
- stall and flush are combinational from registered state plus same-cycle inputs. pend_count is taken from registered state.
- Reset values: all entries invalid, flush_cnt=0, pend_count=0. While rst=1, stall=0 and flush=0 (forced).
- Reset asserted mid-operation clears the scoreboard and flush counter at the next edge.
- Load-use penalty: load issued in cycle t → a dependent instruction in ID stalls for cycles t+1..t+LOAD_LAT and issues at t+LOAD_LAT+1.
- Branch penalty: branch_taken at t → flush high for t..t+FLUSH_CYCLES-1.

## Configuration
- HDU_STORE_BYPASS_EN
  - Defined: a store (0100011) whose only hazard is rs2 matching entries that all have cnt=1 does not stall; the data is forwarded MEM→MEM by the datapath. rs1 (address) hazards still stall.
  - Undefined: stores stall like any other consumer.

## Test plan
- LOAD_LAT=1: load x4 at t, then add x5,x4,x0 in ID at t+1 → stall=1 at t+1 only, pend_count 1→0, add issues at t+2.
- LOAD_LAT=3: same sequence → stall at t+1..t+3; an independent instruction using only x6 → never stalls.
- MAX_PEND=2: three back-to-back loads to x1,x2,x3 with LOAD_LAT=3 → third load stalls until the first entry frees, pend_count never exceeds 2. Loads with rd=x0 never allocate.
- FLUSH_CYCLES=2: branch_taken pulse at t while a data hazard exists → flush=1 at t,t+1, stall=0 at t,t+1; second branch_taken at t+1 → flush extends through t+2.
- rst pulsed with 2 entries pending and flush active → next cycle pend_count=0, stall=0, flush=0; the previously dependent instruction issues.
- HDU_STORE_BYPASS_EN defined: load x7 at t, sw x7,0(x2) at t+1 → no stall. With the macro undefined → stall=1 at t+1.
